// File: rtl/iic_table_writer.sv
// I2C master that walks an external register/data table and writes each entry to one slave
// as a 3-byte write (address+W, register, data), retrying on NACK and reporting exhaustion.
module iic_table_writer #(
   parameter int unsigned CLK_RATE_MHZ = 200,
   parameter int unsigned SCL_KHZ      = 100,
   parameter int unsigned NUM_REGS     = 22,
   parameter int unsigned IDX_W        = 5,
   parameter logic [6:0]  SLAVE_ADDR   = 7'h76,
   parameter int unsigned MAX_RETRIES  = 3,
   parameter int unsigned GAP_QTRS     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [IDX_W-1:0] tbl_idx,
   input  logic [7:0]       tbl_reg,
   input  logic [7:0]       tbl_data,
   input  logic             sda_i,
   output logic             sda_oe,
   output logic             scl_oe,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [IDX_W-1:0] err_idx
);

   localparam int unsigned QTR = CLK_RATE_MHZ * 1000 / (SCL_KHZ * 4);
   localparam int unsigned QW  = (QTR > 1) ? $clog2(QTR) : 1;
   localparam int unsigned GW  = $clog2(GAP_QTRS + 2);

   typedef enum logic [2:0] {
      StIdle, StStart, StByte, StAck, StStop, StGap, StDone, StError
   } state_e;

   state_e           state_q, state_d;
   logic [QW-1:0]    qcnt_q, qcnt_d;
   logic [1:0]       q_q, q_d;
   logic [2:0]       bit_q, bit_d;
   logic [1:0]       byte_q, byte_d;
   logic [7:0]       shift_q, shift_d;
   logic             ack_q, ack_d;
   logic             nack_q, nack_d;
   logic [3:0]       retry_q, retry_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic [IDX_W-1:0] err_idx_q, err_idx_d;
   logic             sda_oe_q, sda_oe_d;
   logic             scl_oe_q, scl_oe_d;
   logic             tick;

   assign tick = (qcnt_q == QW'(QTR - 1));

   // Line drive for a given state/quarter, returned as {sda_oe, scl_oe}.
   function automatic logic [1:0] bus_drive(state_e st, logic [1:0] qq, logic bit_v);
      logic [1:0] d;
      d = 2'b00;
      unique case (st)
         StStart: d = {qq != 2'd0, qq == 2'd3};
         StByte:  d = {~bit_v, (qq == 2'd0) || (qq == 2'd3)};
         StAck:   d = {1'b0, (qq == 2'd0) || (qq == 2'd3)};
         StStop:  d = {qq <= 2'd1, qq == 2'd0};
         default: d = 2'b00;
      endcase
      return d;
   endfunction

   always_comb begin
      state_d   = state_q;
      qcnt_d    = qcnt_q;
      q_d       = q_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      shift_d   = shift_q;
      ack_d     = ack_q;
      nack_d    = nack_q;
      retry_d   = retry_q;
      idx_d     = idx_q;
      gap_d     = gap_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      error_d   = error_q;
      err_idx_d = err_idx_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StStart;
               idx_d   = '0;
               retry_d = '0;
               error_d = 1'b0;
               busy_d  = 1'b1;
               qcnt_d  = '0;
               q_d     = '0;
            end
         end
         StDone, StError: begin
            state_d = StIdle;
            qcnt_d  = '0;
            q_d     = '0;
         end
         default: begin
            qcnt_d = tick ? '0 : qcnt_q + QW'(1);
            if (tick) begin
               q_d = q_q + 2'd1;
               unique case (state_q)
                  StStart: begin
                     if (q_q == 2'd3) begin
                        shift_d = {SLAVE_ADDR, 1'b0};
                        byte_d  = '0;
                        bit_d   = '0;
                        nack_d  = 1'b0;
                        state_d = StByte;
                     end
                  end
                  StByte: begin
                     if (q_q == 2'd3) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = StAck;
                     end
                  end
                  StAck: begin
                     if (q_q == 2'd2) ack_d = sda_i;
                     if (q_q == 2'd3) begin
                        if (ack_q) begin
                           nack_d  = 1'b1;
                           state_d = StStop;
                        end else if (byte_q != 2'd2) begin
                           shift_d = (byte_q == 2'd0) ? tbl_reg : tbl_data;
                           byte_d  = byte_q + 2'd1;
                           bit_d   = '0;
                           state_d = StByte;
                        end else begin
                           state_d = StStop;
                        end
                     end
                  end
                  StStop: begin
                     if (q_q == 2'd3) begin
                        gap_d   = '0;
                        state_d = StGap;
                     end
                  end
                  StGap: begin
                     if (gap_q == GW'(GAP_QTRS - 1)) begin
                        // Quarter phase is free-running in GAP; realign for the next START.
                        q_d = '0;
                        if (nack_q && (retry_q < 4'(MAX_RETRIES))) begin
                           retry_d = retry_q + 4'd1;
                           state_d = StStart;
                        end else if (nack_q) begin
                           error_d   = 1'b1;
                           err_idx_d = idx_q;
                           busy_d    = 1'b0;
                           state_d   = StError;
                        end else if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                           done_d  = 1'b1;
                           busy_d  = 1'b0;
                           state_d = StDone;
                        end else begin
                           idx_d   = idx_q + IDX_W'(1);
                           retry_d = '0;
                           state_d = StStart;
                        end
                     end else begin
                        gap_d = gap_q + GW'(1);
                     end
                  end
                  default: ;
               endcase
            end
         end
      endcase
   end

   assign {sda_oe_d, scl_oe_d} = bus_drive(state_d, q_d, shift_d[7]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         qcnt_q    <= '0;
         q_q       <= '0;
         bit_q     <= '0;
         byte_q    <= '0;
         shift_q   <= '0;
         ack_q     <= 1'b0;
         nack_q    <= 1'b0;
         retry_q   <= '0;
         idx_q     <= '0;
         gap_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         err_idx_q <= '0;
         sda_oe_q  <= 1'b0;
         scl_oe_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         qcnt_q    <= qcnt_d;
         q_q       <= q_d;
         bit_q     <= bit_d;
         byte_q    <= byte_d;
         shift_q   <= shift_d;
         ack_q     <= ack_d;
         nack_q    <= nack_d;
         retry_q   <= retry_d;
         idx_q     <= idx_d;
         gap_q     <= gap_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
         err_idx_q <= err_idx_d;
         sda_oe_q  <= sda_oe_d;
         scl_oe_q  <= scl_oe_d;
      end
   end

   assign tbl_idx = idx_q;
   assign sda_oe  = sda_oe_q;
   assign scl_oe  = scl_oe_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign error   = error_q;
   assign err_idx = err_idx_q;

endmodule

// File: tb/tb_iic_table_writer.sv
// Scoreboarded bench: an I2C slave model decodes bus traffic, and a table-level reference model
// predicts each transaction and the final done/error outcome of a pass.
module tb_iic_table_writer;

   localparam int unsigned CLK_MHZ = 4;
   localparam int unsigned SCL_K   = 250;
   localparam int unsigned NREGS   = 2;
   localparam int unsigned IW      = 2;
   localparam int unsigned MAXR    = 3;
   localparam int unsigned GAPQ    = 4;
   localparam int unsigned QTR     = CLK_MHZ * 1000 / (SCL_K * 4);
   localparam logic [7:0]  ADDR_W  = 8'hEC;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [IW-1:0] tbl_idx, err_idx;
   logic [7:0]    tbl_reg, tbl_data;
   logic          sda_i, sda_oe, scl_oe, busy, done, error;
   logic          slave_pull = 1'b0;
   logic [7:0]    rom_reg [4];
   logic [7:0]    rom_dat [4];

   assign tbl_reg  = rom_reg[tbl_idx];
   assign tbl_data = rom_dat[tbl_idx];
   assign sda_i    = ~(sda_oe | slave_pull);

   always #5 clk = ~clk;

   iic_table_writer #(
      .CLK_RATE_MHZ (CLK_MHZ),
      .SCL_KHZ      (SCL_K),
      .NUM_REGS     (NREGS),
      .IDX_W        (IW),
      .SLAVE_ADDR   (7'h76),
      .MAX_RETRIES  (MAXR),
      .GAP_QTRS     (GAPQ)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .tbl_idx  (tbl_idx),
      .tbl_reg  (tbl_reg),
      .tbl_data (tbl_data),
      .sda_i    (sda_i),
      .sda_oe   (sda_oe),
      .scl_oe   (scl_oe),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .err_idx  (err_idx)
   );

   // kind: 0 = bus transaction, 1 = done pulse, 2 = error raised
   typedef struct {
      int          kind;
      logic [23:0] bytes;
      int          n;
      int          eidx;
   } exp_t;

   exp_t exp_q[$];
   bit   nack_plan [16][3];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   txn_base = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: walk the table applying the slave's planned NACKs.
   task automatic build_expected(output int end_kind);
      int   idx, tries, t;
      bit   nacked;
      exp_t e;
      logic [7:0] bs [3];
      idx = 0; tries = 0; t = 0; end_kind = 0;
      for (int guard = 0; guard < 16; guard++) begin
         bs[0] = ADDR_W; bs[1] = rom_reg[idx]; bs[2] = rom_dat[idx];
         e.kind = 0; e.bytes = '0; e.n = 0; e.eidx = 0; nacked = 0;
         for (int k = 0; k < 3; k++) begin
            e.bytes[23-8*k -: 8] = bs[k];
            e.n++;
            if (nack_plan[t][k]) begin nacked = 1; break; end
         end
         exp_q.push_back(e);
         t++;
         if (nacked) begin
            if (tries == int'(MAXR)) begin
               e.kind = 2; e.bytes = '0; e.n = 0; e.eidx = idx;
               exp_q.push_back(e); end_kind = 2; return;
            end
            tries++;
         end else if (idx == int'(NREGS) - 1) begin
            e.kind = 1; e.bytes = '0; e.n = 0; e.eidx = 0;
            exp_q.push_back(e); end_kind = 1; return;
         end else begin
            idx++; tries = 0;
         end
      end
   endtask

   // Slave model, protocol checker and scoreboard monitor.
   logic        sda_p = 1'b1, scl_p = 1'b1, err_p = 1'b0, busy_p = 1'b0;
   bit          in_txn = 0, acking = 0, have_stop = 0, have_rise = 0;
   int          bitcnt = 0, byte_k = 0, txn = 0, cyc = 0, stop_cyc = 0, rise_cyc = 0;
   int          done_cnt = 0;
   logic [7:0]  cur = '0;
   logic [23:0] obs = '0;

   always @(negedge clk) begin
      logic sda_n, scl_n;
      exp_t e;
      int   rel;
      cyc++;
      sda_n = sda_i;
      scl_n = ~scl_oe;
      if (rst) begin
         in_txn = 0; acking = 0; have_stop = 0; have_rise = 0; bitcnt = 0;
         slave_pull = 1'b0;
         exp_q.delete();
      end else begin
         if (scl_p && scl_n && sda_p && !sda_n) begin
            check("no_repeated_start", in_txn, 0);
            if (have_stop) check("bus_free_time", (cyc - stop_cyc) >= int'(GAPQ * QTR), 1);
            in_txn = 1; bitcnt = 0; byte_k = 0; obs = '0; acking = 0; have_rise = 0;
         end else if (scl_p && scl_n && !sda_p && sda_n) begin
            in_txn = 0; have_stop = 1; stop_cyc = cyc; txn++;
            if (exp_q.size() == 0) begin
               n_vec++; n_fail++;
               $display("FAIL txn_unexpected: got transaction %0h, want none", obs);
            end else begin
               e = exp_q.pop_front();
               check("event_is_txn", e.kind, 0);
               check("txn_nbytes", byte_k, e.n);
               check("txn_bytes", obs, e.bytes);
            end
         end else begin
            if (!scl_p && scl_n && in_txn) begin
               if (have_rise) check("scl_period", cyc - rise_cyc, 4 * QTR);
               have_rise = 1; rise_cyc = cyc;
               if (bitcnt < 8) begin cur = {cur[6:0], sda_n}; bitcnt++; end
            end
            if (scl_p && !scl_n && in_txn) begin
               if (acking) begin
                  slave_pull = 1'b0; acking = 0; bitcnt = 0; byte_k++;
               end else if (bitcnt == 8) begin
                  rel = txn - txn_base;
                  if (byte_k < 3) obs[23-8*byte_k -: 8] = cur;
                  slave_pull = !(rel < 16 && byte_k < 3 && nack_plan[rel][byte_k]);
                  acking = 1;
               end
            end
         end
         if (done) begin
            done_cnt++;
            check("busy_falls_with_done", {busy_p, busy}, 2'b10);
            if (exp_q.size() == 0) begin
               n_vec++; n_fail++;
               $display("FAIL done_unexpected: got done=1, want no event");
            end else begin
               e = exp_q.pop_front();
               check("event_is_done", 1, e.kind);
            end
         end
         if (error && !err_p) begin
            check("busy_low_on_error", busy, 0);
            if (exp_q.size() == 0) begin
               n_vec++; n_fail++;
               $display("FAIL error_unexpected: got error=1, want no event");
            end else begin
               e = exp_q.pop_front();
               check("event_is_error", 2, e.kind);
               check("err_idx", err_idx, e.eidx);
            end
         end
      end
      sda_p = sda_n; scl_p = scl_n; err_p = error; busy_p = busy;
   end

   task automatic clear_plan();
      for (int t = 0; t < 16; t++) for (int k = 0; k < 3; k++) nack_plan[t][k] = 0;
   endtask

   task automatic rand_table();
      for (int i = 0; i < 4; i++) begin
         rom_reg[i] = 8'($urandom);
         rom_dat[i] = 8'($urandom);
      end
   endtask

   task automatic wait_idle(input int budget);
      bit idle;
      idle = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy) begin idle = 1; break; end
      end
      if (!idle) begin
         n_vec++; n_fail++;
         $display("FAIL wait_idle: busy still 1 after %0d cycles, want 0", budget);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic run_pass(input bit mid_start);
      int end_kind, d0;
      build_expected(end_kind);
      d0 = done_cnt;
      txn_base = txn;
      start = 1'b1; @(negedge clk); start = 1'b0;
      check("busy_after_start", busy, 1);
      check("idx_after_start", tbl_idx, 0);
      check("error_cleared_by_start", error, 0);
      if (mid_start) begin
         repeat (150) @(negedge clk);
         check("busy_mid_pass", busy, 1);
         start = 1'b1; @(negedge clk); start = 1'b0;
      end
      wait_idle(20000);
      check("done_pulse_count", done_cnt - d0, (end_kind == 1) ? 1 : 0);
      check("error_flag", error, end_kind == 2);
      check("scoreboard_drained", exp_q.size(), 0);
   endtask

   initial begin
      bit found;
      clear_plan();
      rand_table();
      repeat (3) @(negedge clk);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_scl_oe", scl_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_err_idx", err_idx, 0);
      check("rst_tbl_idx", tbl_idx, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Clean two-entry pass with the reference table.
      rom_reg[0] = 8'h41; rom_dat[0] = 8'h10;
      rom_reg[1] = 8'h98; rom_dat[1] = 8'h03;
      run_pass(0);

      // Single NACK on entry 0 data byte, then retry succeeds.
      rand_table(); clear_plan();
      nack_plan[0][2] = 1;
      run_pass(0);

      // Address always NACKed: retries exhausted on entry 0.
      rand_table(); clear_plan();
      for (int t = 0; t < 16; t++) nack_plan[t][0] = 1;
      run_pass(0);
      check("err_idx_after_exhaust", err_idx, 0);

      // Random tables and NACK patterns, with a stray start mid-pass.
      for (int p = 0; p < 6; p++) begin
         rand_table(); clear_plan();
         for (int t = 0; t < 16; t++)
            for (int k = 0; k < 3; k++) nack_plan[t][k] = ($urandom_range(0, 5) == 0);
         run_pass(1);
      end

      // Asynchronous reset while shifting a byte of entry 1.
      rand_table(); clear_plan();
      begin
         int unused_kind;
         build_expected(unused_kind);
      end
      txn_base = txn;
      start = 1'b1; @(negedge clk); start = 1'b0;
      found = 0;
      for (int w = 0; w < 5000; w++) begin
         @(negedge clk);
         if (tbl_idx == 1 && in_txn && !acking && bitcnt >= 2 && bitcnt < 8 && scl_oe) begin
            found = 1; break;
         end
      end
      if (!found) begin
         n_vec++; n_fail++;
         $display("FAIL reach_entry1_byte: got no entry-1 byte in 5000 cycles, want one");
      end
      #2 rst = 1'b1;
      #1;
      check("arst_sda_oe", sda_oe, 0);
      check("arst_scl_oe", scl_oe, 0);
      check("arst_busy", busy, 0);
      check("arst_tbl_idx", tbl_idx, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rand_table(); clear_plan();
      run_pass(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
